// File: rtl/dsm_pkg.sv
// dsm_pkg: shared constants and saturating-add helper for the delta-sigma modulator
package dsm_pkg;
  typedef struct packed {
    logic signed [31:0] sum;
    logic ovf;
  } sat_t;
  function automatic int fs(input int data_w);
    return 1 << (data_w - 1);
  endfunction
  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction
  function automatic int acc_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction
  function automatic sat_t sat_add(input longint a, input longint b, input int acc_w);
    longint s, hi, lo;
    s = a + b;
    hi = longint'(acc_max(acc_w));
    lo = longint'(acc_min(acc_w));
    return s > hi ? sat_t'{32'(hi), 1'b1} : s < lo ? sat_t'{32'(lo), 1'b1} : sat_t'{32'(s), 1'b0};
  endfunction
endpackage

// File: rtl/dsm_sat_acc.sv
// dsm_sat_acc: saturating accumulator register, advances on en
module dsm_sat_acc
  import dsm_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [ACC_W:0]   addend,
  output logic signed [ACC_W-1:0] acc,
  output logic                    ovf
);
  sat_t r;
  always_comb r = sat_add(longint'(acc), longint'(addend), ACC_W);
  assign ovf = r.ovf;
  always_ff @(posedge CLK)
    if (reset) acc <= '0;
    else if (en) acc <= ACC_W'(r.sum);
endmodule

// File: rtl/dsm_mod2.sv
// dsm_mod2: second-order CIFB delta-sigma modulator with sample handshake and sticky flags
module dsm_mod2
  import dsm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = DATA_W + 4,
  parameter int OSR    = 64
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     bit_out,
  output logic                     ovl,
  output logic                     underrun,
  input  logic                     clr_flags
);
  localparam int CW = $clog2(OSR);
  localparam logic signed [ACC_W:0] FSV = (ACC_W + 1)'(fs(DATA_W));
  logic [CW-1:0] cnt;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [ACC_W-1:0] int1, int2;
  logic signed [ACC_W:0] fb, a1, a2;
  logic ovf1, ovf2, bit_next;
  assign fb = bit_out ? FSV : -FSV;
  assign a1 = (ACC_W + 1)'(x_reg) - fb;
  assign a2 = (ACC_W + 1)'(int1) - fb;
  assign bit_next = longint'(int2) + longint'(a2) >= 0;
  assign din_ready = en && cnt == CW'(OSR - 1);
  dsm_sat_acc #(.ACC_W(ACC_W)) u_int1 (
    .CLK(CLK), .reset(reset), .en(en), .addend(a1), .acc(int1), .ovf(ovf1)
  );
  dsm_sat_acc #(.ACC_W(ACC_W)) u_int2 (
    .CLK(CLK), .reset(reset), .en(en), .addend(a2), .acc(int2), .ovf(ovf2)
  );
  always_ff @(posedge CLK)
    if (reset) begin
      cnt      <= '0;
      x_reg    <= '0;
      bit_out  <= 1'b0;
      ovl      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (en) begin
        cnt     <= din_ready ? '0 : cnt + 1'b1;
        bit_out <= bit_next;
      end
      if (din_ready && din_valid) x_reg <= din;
      ovl      <= (en && (ovf1 || ovf2)) || (ovl && !clr_flags);
      underrun <= (din_ready && !din_valid) || (underrun && !clr_flags);
    end
endmodule

// File: tb/tb_dsm_mod2.sv
// tb_dsm_mod2: scoreboard bench for dsm_mod2 against an integer reference model
module tb_dsm_mod2;
  typedef struct packed {
    int i1, i2, x, cnt, b, ovl, und;
  } mst_t;
  typedef struct packed {
    logic e, rdy;
    mst_t a, b;
  } exp_t;
  logic clk = 0, reset = 1, en = 0, din_valid = 0, clr_flags = 0;
  logic signed [7:0] din = 0;
  logic din_ready, bit_out, ovl, underrun, rdy9, bit9, ovl9, und9;
  int checks = 0, errors = 0, ticks = 0, ones = 0, readies = 0, accepts = 0;
  mst_t m0 = '0, m1 = '0;
  exp_t q[$];
  exp_t cur;
  logic rdy_s;
  always #5 clk = ~clk;
  dsm_mod2 #(.DATA_W(8), .ACC_W(12), .OSR(64)) dut (
    .CLK(clk), .reset(reset), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bit_out(bit_out), .ovl(ovl), .underrun(underrun), .clr_flags(clr_flags)
  );
  dsm_mod2 #(.DATA_W(8), .ACC_W(9), .OSR(64)) dut9 (
    .CLK(clk), .reset(reset), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy9), .bit_out(bit9), .ovl(ovl9), .underrun(und9), .clr_flags(clr_flags)
  );
  function automatic int clip(input int v, input int w);
    return v > (1 << (w - 1)) - 1 ? (1 << (w - 1)) - 1 : v < -(1 << (w - 1)) ? -(1 << (w - 1)) : v;
  endfunction
  function automatic mst_t step(input mst_t s, input int w, input bit r, input bit e, input int d,
                                input bit v, input bit c);
    mst_t n;
    int f, s1, s2;
    bit hit, rdy;
    n = s;
    hit = 0;
    rdy = e && s.cnt == 63;
    f = s.b != 0 ? 128 : -128;
    if (r) return '0;
    if (e) begin
      s1 = s.i1 + s.x - f;
      s2 = s.i2 + s.i1 - f;
      n.i1 = clip(s1, w);
      n.i2 = clip(s2, w);
      hit = n.i1 != s1 || n.i2 != s2;
      n.b = n.i2 >= 0 ? 1 : 0;
      n.cnt = (s.cnt + 1) % 64;
    end
    if (rdy && v) n.x = d;
    n.ovl = (hit || (s.ovl != 0 && !c)) ? 1 : 0;
    n.und = ((rdy && !v) || (s.und != 0 && !c)) ? 1 : 0;
    return n;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic chk_rng(input string n, input int a, input int lo, input int hi);
    checks++;
    if (a < lo || a > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", n, a, lo, hi);
    end
  endtask
  task automatic cycle(input bit r, input bit e, input int d, input bit v, input bit c);
    exp_t x;
    @(negedge clk);
    reset = r;
    en = e;
    din = 8'(d);
    din_valid = v;
    clr_flags = c;
    x.e = e && !r;
    x.rdy = e && m0.cnt == 63;
    m0 = step(m0, 12, r, e, d, v, c);
    m1 = step(m1, 9, r, e, d, v, c);
    x.a = m0;
    x.b = m1;
    q.push_back(x);
  endtask
  task automatic settle;
    @(posedge clk);
    #2;
  endtask
  task automatic run(input int n, input int d, input bit v);
    repeat (n) cycle(0, 1, d, v, 0);
    settle();
  endtask
  task automatic zero_counts;
    ticks = 0;
    ones = 0;
    readies = 0;
    accepts = 0;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    rdy_s = din_ready;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("din_ready", int'(rdy_s), int'(cur.rdy));
      chk("bit_out", int'(bit_out), cur.a.b);
      chk("ovl", int'(ovl), cur.a.ovl);
      chk("underrun", int'(underrun), cur.a.und);
      chk("int1", int'(dut.u_int1.acc), cur.a.i1);
      chk("int2", int'(dut.u_int2.acc), cur.a.i2);
      chk("x_reg", int'(dut.x_reg), cur.a.x);
      chk("bit9_known", int'($isunknown(bit9)), 0);
      chk("bit9", int'(bit9), cur.b.b);
      chk("ovl9", int'(ovl9), cur.b.ovl);
      chk("int1_9", int'(dut9.u_int1.acc), cur.b.i1);
      chk("int2_9", int'(dut9.u_int2.acc), cur.b.i2);
      if (cur.e) begin
        ticks++;
        ones += int'(bit_out);
      end
      if (rdy_s) readies++;
      if (rdy_s && din_valid && !reset) accepts++;
    end
  end
  initial begin
    int tgt[2];
    int dcv[2];
    tgt = '{2048, -3072};
    dcv = '{64, -96};
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    settle();
    chk("rst_bit_out", int'(bit_out), 0);
    chk("rst_int1", int'(dut.u_int1.acc), 0);
    chk("rst_int2", int'(dut.u_int2.acc), 0);
    cycle(0, 1, 0, 0, 0);
    settle();
    chk("t1_int1", int'(dut.u_int1.acc), 128);
    chk("t1_int2", int'(dut.u_int2.acc), 128);
    chk("t1_bit_out", int'(bit_out), 1);
    zero_counts();
    run(62, 0, 0);
    chk("no_early_ready", readies, 0);
    chk("no_early_underrun", int'(underrun), 0);
    run(1, 0, 0);
    chk("ready_tick64", readies, 1);
    chk("underrun_after64", int'(underrun), 1);
    cycle(1, 0, 0, 0, 0);
    zero_counts();
    run(4096, 0, 1);
    chk_rng("zero_ones", ones, 2044, 2052);
    chk("zero_ovl", int'(ovl), 0);
    chk("zero_underrun", int'(underrun), 0);
    chk("one_per_frame", accepts, 64);
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 0, 0, 0);
      run(64, dcv[k], 1);
      zero_counts();
      run(4096, dcv[k], 1);
      chk_rng("dc_mean", 2 * ones - ticks, tgt[k] - 41, tgt[k] + 41);
    end
    cycle(1, 0, 0, 0, 0);
    zero_counts();
    repeat (640) cycle(0, 1'($urandom_range(1)), int'($urandom_range(255)) - 128, 1, 0);
    settle();
    chk("rand_readies", readies, ticks / 64);
    zero_counts();
    run(64, 5, 0);
    chk("miss_x_hold", int'(dut.x_reg), m0.x);
    chk("miss_no_accept", accepts, 0);
    chk("miss_underrun", int'(underrun), 1);
    cycle(1, 0, 0, 0, 0);
    run(63, 0, 0);
    chk("und_before", int'(underrun), 0);
    cycle(0, 1, 0, 0, 1);
    settle();
    chk("und_set_wins", int'(underrun), 1);
    cycle(0, 0, 0, 0, 1);
    settle();
    chk("und_clr", int'(underrun), 0);
    cycle(1, 0, 0, 0, 0);
    run(576, 127, 1);
    chk("ovl9_rise", int'(ovl9), 1);
    cycle(0, 0, 127, 1, 1);
    settle();
    chk("ovl9_clr", int'(ovl9), 0);
    chk("ovl_clr", int'(ovl), 0);
    cycle(1, 0, 0, 0, 0);
    run(94, 64, 1);
    chk("pre_rst_x", int'(dut.x_reg), 64);
    cycle(1, 1, 64, 1, 0);
    settle();
    chk("mid_rst_bit", int'(bit_out), 0);
    chk("mid_rst_int1", int'(dut.u_int1.acc), 0);
    chk("mid_rst_int2", int'(dut.u_int2.acc), 0);
    chk("mid_rst_x", int'(dut.x_reg), 0);
    zero_counts();
    run(63, 64, 1);
    chk("mid_rst_no_ready", readies, 0);
    run(1, 64, 1);
    chk("mid_rst_ready64", readies, 1);
    settle();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
